// File: rtl/pc_redirect_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pc_redirect_ctrl_pkg
// Brief   : Shared pipeline-control definitions for the PC redirect sequencer:
//           state encoding, flush-length bounds and flush-counter helper.
// Revision: 1.0 - initial release
// ============================================================================
package pc_redirect_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_DRAIN    = 2'd2
    } redir_state_e;

    localparam int c_FLUSH_CYCLES_MIN = 1;
    localparam int c_FLUSH_CYCLES_MAX = 15;
    localparam int c_FLUSH_CNT_W      = 4;

    // Down-count that holds at zero.
    function automatic logic [c_FLUSH_CNT_W-1:0] flush_cnt_dec(
        input logic [c_FLUSH_CNT_W-1:0] cnt
    );
        return (cnt == '0) ? '0 : cnt - 4'd1;
    endfunction

endpackage : pc_redirect_ctrl_pkg
`default_nettype wire

// File: rtl/pc_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : pc_redirect_ctrl
// Brief   : Turns an execute-stage taken decision into a held fetch redirect,
//           a multi-cycle IF/ID + ID/EX flush and a redirect statistics count.
// Revision: 1.0 - initial release
// ============================================================================
module pc_redirect_ctrl
    import pc_redirect_ctrl_pkg::*;
#(
    parameter int PC_WIDTH     = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ex_valid,
    input  logic                 select_new_pc,
    input  logic [PC_WIDTH-1:0]  pc_target,
    input  logic                 stall_in,
    input  logic                 fetch_ready,
    output logic                 redirect_valid,
    output logic [PC_WIDTH-1:0]  redirect_pc,
    output logic                 flush_if_id,
    output logic                 flush_id_ex,
    output logic                 busy,
    output logic                 misaligned,
    output logic [CNT_WIDTH-1:0] redirect_count
);

    localparam int c_FLUSH_EFF =
        (FLUSH_CYCLES < c_FLUSH_CYCLES_MIN) ? c_FLUSH_CYCLES_MIN :
        (FLUSH_CYCLES > c_FLUSH_CYCLES_MAX) ? c_FLUSH_CYCLES_MAX : FLUSH_CYCLES;
    localparam logic [c_FLUSH_CNT_W-1:0] c_FLUSH_LOAD = c_FLUSH_CNT_W'(c_FLUSH_EFF - 1);
    localparam logic [CNT_WIDTH-1:0]     c_CNT_ONE    = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    redir_state_e               r_state;
    redir_state_e               w_state_nxt;
    logic [c_FLUSH_CNT_W-1:0]   r_flush_cnt;
    logic [c_FLUSH_CNT_W-1:0]   w_flush_cnt_nxt;
    logic [PC_WIDTH-1:0]        r_redirect_pc;
    logic                       r_misaligned;
    logic [CNT_WIDTH-1:0]       r_redirect_count;
    logic                       w_trigger;

    // Only sampled in IDLE: anything seen while flushing is wrong-path.
    assign w_trigger = (r_state == ST_IDLE) & ex_valid & select_new_pc & ~stall_in;

    always_comb begin
        w_state_nxt     = r_state;
        w_flush_cnt_nxt = r_flush_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_trigger) begin
                    w_state_nxt     = ST_REDIRECT;
                    w_flush_cnt_nxt = c_FLUSH_LOAD;
                end
            end
            ST_REDIRECT: begin
                w_flush_cnt_nxt = flush_cnt_dec(r_flush_cnt);
                if (fetch_ready) begin
                    w_state_nxt = (r_flush_cnt == '0) ? ST_IDLE : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                w_flush_cnt_nxt = flush_cnt_dec(r_flush_cnt);
                if (r_flush_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt     = ST_IDLE;
                w_flush_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= ST_IDLE;
            r_flush_cnt      <= '0;
            r_redirect_pc    <= '0;
            r_misaligned     <= 1'b0;
            r_redirect_count <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_flush_cnt  <= w_flush_cnt_nxt;
            r_misaligned <= w_trigger & (|pc_target[1:0]);
            if (w_trigger) begin
                r_redirect_pc    <= {pc_target[PC_WIDTH-1:2], 2'b00};
                r_redirect_count <= r_redirect_count + c_CNT_ONE;
            end
        end
    end

    assign redirect_valid = (r_state == ST_REDIRECT);
    assign flush_if_id    = (r_state != ST_IDLE);
    assign flush_id_ex    = (r_state != ST_IDLE);
    assign busy           = (r_state != ST_IDLE);
    assign misaligned     = r_misaligned;
    assign redirect_pc    = r_redirect_pc;
    assign redirect_count = r_redirect_count;

endmodule : pc_redirect_ctrl
`default_nettype wire

// File: tb/tb_pc_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_pc_redirect_ctrl
// Brief   : Self-checking bench for pc_redirect_ctrl with an accepted-redirect
//           scoreboard and per-scenario timing checks.
// Revision: 1.0 - initial release
// ============================================================================
module tb_pc_redirect_ctrl;

    localparam int c_CNT_W = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               ex_valid = 1'b0;
    logic               select_new_pc = 1'b0;
    logic [31:0]        pc_target = '0;
    logic               stall_in = 1'b0;
    logic               fetch_ready = 1'b1;
    logic               redirect_valid;
    logic [31:0]        redirect_pc;
    logic               flush_if_id;
    logic               flush_id_ex;
    logic               busy;
    logic               misaligned;
    logic [c_CNT_W-1:0] redirect_count;

    typedef struct {
        logic [31:0]        pc;
        logic [c_CNT_W-1:0] cnt;
    } exp_t;

    exp_t               sb_q[$];
    logic [c_CNT_W-1:0] exp_count = '0;
    int                 n_checks = 0;
    int                 n_fail = 0;

    pc_redirect_ctrl #(
        .PC_WIDTH     (32),
        .FLUSH_CYCLES (2),
        .CNT_WIDTH    (c_CNT_W)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .ex_valid       (ex_valid),
        .select_new_pc  (select_new_pc),
        .pc_target      (pc_target),
        .stall_in       (stall_in),
        .fetch_ready    (fetch_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush_if_id    (flush_if_id),
        .flush_id_ex    (flush_id_ex),
        .busy           (busy),
        .misaligned     (misaligned),
        .redirect_count (redirect_count)
    );

    always #5 clk = ~clk;

    // Scoreboard: every accepted redirect must match the oldest pushed expectation.
    always @(negedge clk) begin
        if (!rst && redirect_valid && fetch_ready) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: redirect_pc=%h accepted with no expected redirect", redirect_pc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if (redirect_pc !== e.pc || redirect_count !== e.cnt) begin
                    n_fail++;
                    $display("FAIL sb_accept: pc=%h cnt=%0d expected pc=%h cnt=%0d",
                             redirect_pc, redirect_count, e.pc, e.cnt);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_trigger(input logic [31:0] tgt, input bit expect_accept);
        ex_valid      = 1'b1;
        select_new_pc = 1'b1;
        pc_target     = tgt;
        if (expect_accept) begin
            exp_count = exp_count + 1'b1;
            sb_q.push_back('{pc: {tgt[31:2], 2'b00}, cnt: exp_count});
        end
    endtask

    task automatic clear_trigger();
        ex_valid      = 1'b0;
        select_new_pc = 1'b0;
    endtask

    // Observes one redirect from T+1 until busy falls; optional retrigger at cycle retrig_at.
    task automatic measure(input int ready_delay, input int retrig_at,
                           output int flush_n, output int rv_n, output int drain_n,
                           output int mis_n, output bit pc_changed, output bit timed_out);
        int k = 0;
        logic [31:0] pc0;
        flush_n = 0; rv_n = 0; drain_n = 0; mis_n = 0; pc_changed = 0;
        pc0 = redirect_pc;
        while (busy && k < 100) begin
            fetch_ready = (k >= ready_delay);
            if (k == retrig_at) drive_trigger(32'h0000_0BAD, 1'b0);
            else if (k == retrig_at + 1) clear_trigger();
            if (flush_if_id && flush_id_ex) flush_n++;
            if (redirect_valid) rv_n++;
            if (flush_if_id && !redirect_valid) drain_n++;
            if (misaligned) mis_n++;
            if (redirect_pc !== pc0) pc_changed = 1;
            cyc();
            k++;
        end
        clear_trigger();
        fetch_ready = 1'b1;
        timed_out = (k >= 100);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        sb_q.delete();
        exp_count = '0;
        cyc();
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        n_checks++;
        if ({redirect_valid, flush_if_id, flush_id_ex, busy, misaligned} !== 5'b0 ||
            redirect_pc !== 32'h0 || redirect_count !== '0) begin
            n_fail++;
            $display("FAIL reset_state: rv=%b fl=%b%b busy=%b mis=%b pc=%h cnt=%0d expected all 0",
                     redirect_valid, flush_if_id, flush_id_ex, busy, misaligned, redirect_pc, redirect_count);
        end
        rst = 1'b0;
        cyc();
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: busy=%b expected 0", busy);
        end
    endtask

    task automatic test_basic();
        int f, r, d, m; bit pc_ch, to;
        drive_trigger(32'h0000_0100, 1'b1);
        cyc();
        clear_trigger();
        n_checks++;
        if (redirect_valid !== 1'b1 || flush_if_id !== 1'b1 || flush_id_ex !== 1'b1 ||
            busy !== 1'b1 || misaligned !== 1'b0 || redirect_pc !== 32'h100 || redirect_count !== 4'd1) begin
            n_fail++;
            $display("FAIL basic_t1: rv=%b fl=%b%b busy=%b mis=%b pc=%h cnt=%0d expected 1 11 1 0 00000100 1",
                     redirect_valid, flush_if_id, flush_id_ex, busy, misaligned, redirect_pc, redirect_count);
        end
        measure(0, -10, f, r, d, m, pc_ch, to);
        n_checks++;
        if (to || f != 2 || r != 1 || d != 1 || m != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_timing: flush=%0d rv=%0d drain=%0d mis=%0d busy=%b to=%b expected 2 1 1 0 0 0",
                     f, r, d, m, busy, to);
        end
    endtask

    task automatic test_backpressure();
        int f, r, d, m; bit pc_ch, to;
        fetch_ready = 1'b0;
        drive_trigger(32'h0000_1234, 1'b1);
        cyc();
        clear_trigger();
        measure(4, -10, f, r, d, m, pc_ch, to);
        n_checks++;
        if (to || f != 5 || r != 5 || d != 0 || pc_ch) begin
            n_fail++;
            $display("FAIL backpressure: flush=%0d rv=%0d drain=%0d pc_changed=%b to=%b expected 5 5 0 0 0",
                     f, r, d, pc_ch, to);
        end
        n_checks++;
        if (redirect_count !== exp_count) begin
            n_fail++;
            $display("FAIL backpressure_count: cnt=%0d expected %0d", redirect_count, exp_count);
        end
    endtask

    task automatic test_stall();
        int f, r, d, m; bit pc_ch, to;
        stall_in = 1'b1;
        drive_trigger(32'h0000_0400, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_checks++;
            if (busy !== 1'b0 || redirect_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold: busy=%b rv=%b expected 0 0", busy, redirect_valid);
            end
        end
        stall_in = 1'b0;
        drive_trigger(32'h0000_0400, 1'b1);
        cyc();
        clear_trigger();
        n_checks++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h400) begin
            n_fail++;
            $display("FAIL stall_release: rv=%b pc=%h expected 1 00000400", redirect_valid, redirect_pc);
        end
        measure(0, -10, f, r, d, m, pc_ch, to);
        n_checks++;
        if (to || f != 2) begin
            n_fail++;
            $display("FAIL stall_flush: flush=%0d to=%b expected 2 0", f, to);
        end
    endtask

    task automatic test_ignored();
        int f, r, d, m; bit pc_ch, to;
        drive_trigger(32'h0000_0500, 1'b1);
        cyc();
        clear_trigger();
        measure(0, 1, f, r, d, m, pc_ch, to);
        cyc();
        n_checks++;
        if (to || busy !== 1'b0 || redirect_count !== exp_count || redirect_pc !== 32'h500 || f != 2) begin
            n_fail++;
            $display("FAIL ignored_trigger: busy=%b cnt=%0d pc=%h flush=%0d expected 0 %0d 00000500 2",
                     busy, redirect_count, redirect_pc, f, exp_count);
        end
    endtask

    task automatic test_misaligned();
        int f, r, d, m; bit pc_ch, to;
        drive_trigger(32'h0000_0203, 1'b1);
        cyc();
        clear_trigger();
        n_checks++;
        if (misaligned !== 1'b1 || redirect_pc !== 32'h200) begin
            n_fail++;
            $display("FAIL misaligned_t1: mis=%b pc=%h expected 1 00000200", misaligned, redirect_pc);
        end
        measure(0, -10, f, r, d, m, pc_ch, to);
        n_checks++;
        if (to || m != 1) begin
            n_fail++;
            $display("FAIL misaligned_pulse: pulse_cycles=%0d expected 1", m);
        end
    endtask

    task automatic test_reset_mid();
        int f, r, d, m; bit pc_ch, to;
        fetch_ready = 1'b0;
        drive_trigger(32'h0000_0303, 1'b1);
        cyc();
        clear_trigger();
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({redirect_valid, flush_if_id, flush_id_ex, busy, misaligned} !== 5'b0 ||
            redirect_pc !== 32'h0 || redirect_count !== '0) begin
            n_fail++;
            $display("FAIL reset_async: rv=%b fl=%b%b busy=%b mis=%b pc=%h cnt=%0d expected all 0",
                     redirect_valid, flush_if_id, flush_id_ex, busy, misaligned, redirect_pc, redirect_count);
        end
        sb_q.delete();
        exp_count = '0;
        fetch_ready = 1'b1;
        cyc();
        rst = 1'b0;
        cyc();
        drive_trigger(32'h0000_0700, 1'b1);
        cyc();
        clear_trigger();
        measure(0, -10, f, r, d, m, pc_ch, to);
        n_checks++;
        if (to || f != 2 || r != 1 || redirect_count !== 4'd1) begin
            n_fail++;
            $display("FAIL reset_recover: flush=%0d rv=%0d cnt=%0d expected 2 1 1", f, r, redirect_count);
        end
    endtask

    task automatic test_back_to_back();
        int f, r, d, m; bit pc_ch, to;
        int n_to = 0;
        apply_reset();
        for (int i = 0; i < 17; i++) begin
            drive_trigger(32'h0000_1000 + 32'(i * 4), 1'b1);
            cyc();
            clear_trigger();
            measure(0, -10, f, r, d, m, pc_ch, to);
            if (to) n_to++;
        end
        n_checks++;
        if (n_to != 0 || redirect_count !== 4'd1) begin
            n_fail++;
            $display("FAIL count_wrap: cnt=%0d timeouts=%0d expected 1 0", redirect_count, n_to);
        end
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d redirects never accepted, expected 0", sb_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_stall();
        test_ignored();
        test_misaligned();
        test_reset_mid();
        test_back_to_back();
        cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_pc_redirect_ctrl
`default_nettype wire

// File: doc/pc_redirect_ctrl.md
# pc_redirect_ctrl

Sequencer for the execute-stage branch/jump resolution path. It accepts the resolved taken decision and target from the execute stage (`select_new_pc` / `pc_out`) and turns it into a held redirect request to instruction fetch. It also drives a multi-cycle flush of the IF/ID and ID/EX pipeline registers and keeps a running count of taken redirects. It sits between the execute stage, the fetch unit and the pipeline-register flush inputs.

## Interface
Parameters:
- `PC_WIDTH`, 32, width of program counter / target address
- `FLUSH_CYCLES`, 2, minimum number of cycles the flush outputs are held; legal range 1..15
- `CNT_WIDTH`, 16, width of the redirect statistics counter

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge
- `rst`  in  1  asynchronous, active-high reset
- `ex_valid`  in  1  execute stage holds a valid (non-bubble) instruction
- `select_new_pc`  in  1  execute stage resolved a jump or a taken branch
- `pc_target`  in  PC_WIDTH  resolved target address from execute
- `stall_in`  in  1  pipeline hazard stall; execute instruction is held, not retired
- `fetch_ready`  in  1  fetch unit accepts `redirect_pc` this cycle
- `redirect_valid`  out  1  redirect request to fetch, held until accepted
- `redirect_pc`  out  PC_WIDTH  target to fetch, word-aligned (bits [1:0] = 0)
- `flush_if_id`  out  1  clear IF/ID register
- `flush_id_ex`  out  1  clear ID/EX register
- `busy`  out  1  controller not in IDLE
- `misaligned`  out  1  one-cycle pulse: accepted target had non-zero bits [1:0]
- `redirect_count`  out  CNT_WIDTH  number of accepted redirects, wraps modulo 2^CNT_WIDTH

## Operation
- **Trigger:** `ex_valid & select_new_pc & ~stall_in`. A trigger is sampled only in IDLE; triggers are ignored in any other state, because the execute instruction is on the flushed wrong path.
- **On trigger:**
  - latch `{pc_target[PC_WIDTH-1:2], 2'b00}` into `redirect_pc`
  - load the flush counter with FLUSH_CYCLES-1
  - pulse `misaligned` next cycle if `pc_target[1:0] != 0`
  - increment `redirect_count`
  - go to REDIRECT
- **IDLE:** `redirect_valid` = 0, both flushes = 0, `busy` = 0.
- **REDIRECT:**
  - `redirect_valid` = 1 and both flushes = 1.
  - The counter decrements each cycle, saturating at 0.
  - If `fetch_ready` is high: go to IDLE when the counter value this cycle is 0, otherwise go to DRAIN.
  - If `fetch_ready` is low: stay in REDIRECT. Flushes remain high, so fetch output keeps being discarded.
- **DRAIN:**
  - `redirect_valid` = 0 and both flushes = 1.
  - The counter decrements each cycle.
  - Go to IDLE in the cycle where the counter value is 0.
- `redirect_pc` is stable from entry to REDIRECT until the next trigger.
- **Reset (any time, including mid-redirect):**
  - state to IDLE immediately
  - `redirect_valid`, flushes, `busy`, `misaligned` = 0
  - `redirect_pc` = 0, `redirect_count` = 0, flush counter = 0
- **Counter wrap:** `redirect_count` wraps from all-ones to 0 without a flag.

## Timing
- Trigger sampled at edge closing cycle T; `redirect_valid`, flushes, `busy` and `misaligned` are high from cycle T+1 (all outputs registered).
- **Flush duration:** exactly max(FLUSH_CYCLES, A) cycles, where A is the number of REDIRECT cycles up to and including the one where `fetch_ready` is high.
- **FLUSH_CYCLES=1, `fetch_ready`=1 at T+1:** single-cycle redirect/flush; IDLE at T+2; a new trigger can be sampled in T+2.
- **Trigger in the final DRAIN cycle:** ignored (state is not IDLE that cycle).
- `stall_in` high with `select_new_pc` high in IDLE: no action. The instruction is re-presented once the stall clears.
- `fetch_ready` has no effect outside REDIRECT.

## Structure
- State encoding (IDLE=0, REDIRECT=1, DRAIN=2) and FLUSH_CYCLES bounds belong in the shared core defines package alongside the other pipeline-control constants.
- Single module. The flush counter is a small saturating down-counter inlined; no sub-module is warranted.

## Test plan
- **Basic redirect:** FLUSH_CYCLES=2, trigger with `pc_target`=0x0000_0100, `fetch_ready`=1 → `redirect_valid` high 1 cycle with `redirect_pc`=0x100; flushes high 2 cycles; `redirect_count`=1; `busy` low after 2 cycles.
- **Fetch backpressure:** trigger, `fetch_ready` low 4 cycles then high → `redirect_valid` held 5 cycles with a constant target; flushes high 5 cycles; no DRAIN.
- **Stall and ignored trigger:**
  - `stall_in`=1 with a valid trigger → no redirect.
  - `stall_in` released → redirect at the next cycle.
  - A second trigger during DRAIN is ignored; `redirect_count` increments only once.
- **Misaligned target:** `pc_target`=0x0000_0203 → `redirect_pc`=0x0000_0200; `misaligned` pulses 1 cycle at T+1.
- **Reset mid-redirect:** assert `rst` while in REDIRECT with `fetch_ready`=0 → all outputs 0 asynchronously; `redirect_count`=0; a trigger after reset release works normally.
- **Counter wrap:** CNT_WIDTH=4, 17 back-to-back redirects → `redirect_count`=1.
